// File: rtl/mips_regfile_pkg.sv
// Shared constants, typedefs and helpers for the multi-port MIPS register file.
// Optional parity (REGFILE_PARITY_EN) lives in mips_regfile_mp; nothing here depends on it.
package mips_regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    // Widest busy vector popcount supports (ADDR_W up to 8).
    localparam int MAX_DEPTH  = 256;

    typedef logic [DATA_W_DEF-1:0] rf_data_t;
    typedef logic [ADDR_W_DEF-1:0] rf_addr_t;

    function automatic int unsigned popcount(input logic [MAX_DEPTH-1:0] v);
        int unsigned c;
        c = 0;
        for (int k = 0; k < MAX_DEPTH; k++) begin
            c = c + 32'(v[k]);
        end
        return c;
    endfunction

endpackage

// File: rtl/mips_regfile_mp_scoreboard.sv
// Pending-write scoreboard: issue claims a destination, writeback releases it,
// flush clears everything. Claims win over same-cycle releases (younger producer).
module regfile_scoreboard
    import mips_regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NRD    = 4,
    parameter int NWR    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*ADDR_W-1:0] wr_addr,
    input  logic [NWR-1:0]        clm_en,
    input  logic [NWR*ADDR_W-1:0] clm_addr,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD-1:0]        rd_busy,
    output logic [ADDR_W:0]       busy_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0]     busy;
    logic [DEPTH-1:0]     busy_nxt;
    logic [MAX_DEPTH-1:0] busy_ext;

    // Releases are applied first so a claim on the same address overrides them.
    always_comb begin
        busy_nxt = busy;
        busy_ext = '0;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j]) begin
                busy_nxt[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        for (int j = 0; j < NWR; j++) begin
            if (clm_en[j]) begin
                busy_nxt[clm_addr[j*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
        busy_nxt[0] = 1'b0;
        if (flush) begin
            busy_nxt = '0;
        end
        busy_ext[DEPTH-1:0] = busy_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= (ADDR_W+1)'(popcount(busy_ext));
        end
    end

    // A writeback landing this cycle satisfies the dependency, so no stall.
    always_comb begin
        logic [ADDR_W-1:0] a;
        logic              hit;
        rd_busy = '0;
        a       = '0;
        hit     = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            a   = rd_addr[i*ADDR_W +: ADDR_W];
            hit = 1'b0;
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == a)) begin
                    hit = 1'b1;
                end
            end
            rd_busy[i] = busy[a] && !hit && (a != '0);
        end
    end

endmodule

// File: rtl/mips_regfile_mp.sv
// Multi-port MIPS GPR file with same-cycle write bypass and pending-write scoreboard.
// Define REGFILE_PARITY_EN to store per-entry even parity and flag read mismatches on par_err.
module mips_regfile_mp
    import mips_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NRD    = 4,
    parameter int NWR    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*ADDR_W-1:0] wr_addr,
    input  logic [NWR*DATA_W-1:0] wr_data,
    input  logic [NWR-1:0]        clm_en,
    input  logic [NWR*ADDR_W-1:0] clm_addr,
    input  logic                  flush,
    output logic [ADDR_W:0]       busy_cnt,
    output logic                  par_err
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Ascending port order means the highest-index writer to an address wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] != '0)) begin
                    mem[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] v;
        rd_data = '0;
        a       = '0;
        v       = '0;
        for (int i = 0; i < NRD; i++) begin
            a = rd_addr[i*ADDR_W +: ADDR_W];
            v = mem[a];
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == a)) begin
                    v = wr_data[j*DATA_W +: DATA_W];
                end
            end
            if (rst || (a == '0)) begin
                v = '0;
            end
            rd_data[i*DATA_W +: DATA_W] = v;
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NRD    (NRD),
        .NWR    (NWR)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .clm_en   (clm_en),
        .clm_addr (clm_addr),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy),
        .busy_cnt (busy_cnt)
    );

`ifdef REGFILE_PARITY_EN
    logic par_mem [DEPTH];
    logic par_hit;
    logic par_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                par_mem[k] <= 1'b0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] != '0)) begin
                    par_mem[wr_addr[j*ADDR_W +: ADDR_W]] <= ^wr_data[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Only reads actually served from the array can expose a corrupted entry.
    always_comb begin
        logic [ADDR_W-1:0] a;
        logic              bp;
        par_hit = 1'b0;
        a       = '0;
        bp      = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            a  = rd_addr[i*ADDR_W +: ADDR_W];
            bp = 1'b0;
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == a)) begin
                    bp = 1'b1;
                end
            end
            if (!rst && (a != '0) && !bp && ((^mem[a]) != par_mem[a])) begin
                par_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_err_q <= 1'b0;
        end else if (par_hit) begin
            par_err_q <= 1'b1;
        end
    end

    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_mips_regfile_mp.sv
// Randomized self-checking bench for mips_regfile_mp against an architectural model
// (register array, busy set, sticky parity flag); parity scenario runs when REGFILE_PARITY_EN is defined.
module tb_mips_regfile_mp;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NRD = 4;
    localparam int NWR = 2;

    logic                clk;
    logic                rst;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*DW-1:0]   rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*DW-1:0]   wr_data;
    logic [NWR-1:0]      clm_en;
    logic [NWR*AW-1:0]   clm_addr;
    logic                flush;
    logic [AW:0]         busy_cnt;
    logic                par_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_reg [32];
    bit          m_busy [32];
    bit          m_bad [32];
    bit          m_par;

    mips_regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD), .NWR(NWR)) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .clm_en   (clm_en),
        .clm_addr (clm_addr),
        .flush    (flush),
        .busy_cnt (busy_cnt),
        .par_err  (par_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int wa(int j);  return int'(wr_addr[j*AW +: AW]);  endfunction
    function automatic int ca(int j);  return int'(clm_addr[j*AW +: AW]); endfunction
    function automatic int ra(int i);  return int'(rd_addr[i*AW +: AW]);  endfunction

    function automatic bit written_now(int a);
        for (int j = 0; j < NWR; j++) if (wr_en[j] && wa(j) == a) return 1'b1;
        return 1'b0;
    endfunction

    // Architectural read: the last port writing this address this cycle supplies the value.
    function automatic logic [31:0] exp_read(int a);
        logic [31:0] v;
        if (rst || a == 0) return 32'h0;
        v = m_reg[a];
        for (int j = 0; j < NWR; j++) if (wr_en[j] && wa(j) == a) v = wr_data[j*DW +: DW];
        return v;
    endfunction

    function automatic logic [31:0] exp_busy(int a);
        if (rst || a == 0) return 32'h0;
        return (m_busy[a] && !written_now(a)) ? 32'h1 : 32'h0;
    endfunction

    function automatic logic [31:0] m_count();
        int c = 0;
        for (int a = 0; a < 32; a++) c += int'(m_busy[a]);
        return 32'(c);
    endfunction

    task automatic model_clear();
        for (int a = 0; a < 32; a++) begin
            m_reg[a]  = '0;
            m_busy[a] = 1'b0;
            m_bad[a]  = 1'b0;
        end
        m_par = 1'b0;
    endtask

    task automatic model_update();
        bit claimed;
        if (rst) begin
            model_clear();
            return;
        end
        for (int i = 0; i < NRD; i++)
            if (ra(i) != 0 && !written_now(ra(i)) && m_bad[ra(i)]) m_par = 1'b1;
        for (int a = 1; a < 32; a++) begin
            claimed = 1'b0;
            for (int j = 0; j < NWR; j++) if (clm_en[j] && ca(j) == a) claimed = 1'b1;
            if (flush)               m_busy[a] = 1'b0;
            else if (claimed)        m_busy[a] = 1'b1;
            else if (written_now(a)) m_busy[a] = 1'b0;
        end
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && wa(j) != 0) begin
                m_reg[wa(j)] = wr_data[j*DW +: DW];
                m_bad[wa(j)] = 1'b0;
            end
        end
    endtask

    task automatic clear_inputs();
        rd_addr  = '0;
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        clm_en   = '0;
        clm_addr = '0;
        flush    = 1'b0;
    endtask

    // Called at negedge with inputs set: check comb outputs, clock, check registered outputs.
    task automatic applyStimulus();
        #1;
        for (int i = 0; i < NRD; i++) begin
            checkOutput($sformatf("rd_data%0d_r%0d", i, ra(i)), rd_data[i*DW +: DW], exp_read(ra(i)));
            checkOutput($sformatf("rd_busy%0d_r%0d", i, ra(i)), 32'(rd_busy[i]), exp_busy(ra(i)));
        end
        @(posedge clk);
        model_update();
        #1;
        checkOutput("busy_cnt", 32'(busy_cnt), m_count());
        checkOutput("par_err", 32'(par_err), 32'(m_par));
        @(negedge clk);
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    task automatic random_inputs();
        for (int i = 0; i < NRD; i++) rd_addr[i*AW +: AW] = rnd_addr();
        for (int j = 0; j < NWR; j++) begin
            wr_en[j]              = ($urandom_range(0, 1) == 1);
            wr_addr[j*AW +: AW]   = rnd_addr();
            wr_data[j*DW +: DW]   = $urandom;
            clm_en[j]             = ($urandom_range(0, 2) == 0);
            clm_addr[j*AW +: AW]  = rnd_addr();
        end
        flush = ($urandom_range(0, 19) == 0);
    endtask

    initial begin
        model_clear();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Same address on both write ports: port 1 wins, in bypass and in storage.
        wr_en = 2'b11;
        wr_addr = {5'd5, 5'd5};
        wr_data = {32'h22, 32'h11};
        rd_addr[0 +: AW] = 5'd5;
        #1 checkOutput("t2_bypass_r5", rd_data[31:0], 32'h22);
        applyStimulus();
        clear_inputs();
        rd_addr[0 +: AW] = 5'd5;
        #1 checkOutput("t2_stored_r5", rd_data[31:0], 32'h22);
        applyStimulus();

        // Register 0 ignores writes and claims.
        wr_en = 2'b01;
        wr_data[0 +: DW] = 32'hFFFF_FFFF;
        clm_en = 2'b01;
        applyStimulus();
        clear_inputs();
        checkOutput("t3_r0_cnt", 32'(busy_cnt), 32'h0);
        applyStimulus();

        // Claim r7, observe busy, then release with a write three cycles later.
        clm_en = 2'b01;
        clm_addr[0 +: AW] = 5'd7;
        rd_addr[0 +: AW] = 5'd7;
        applyStimulus();
        clm_en = '0;
        checkOutput("t4_cnt_c1", 32'(busy_cnt), 32'h1);
        #1 checkOutput("t4_busy_c1", 32'(rd_busy[0]), 32'h1);
        applyStimulus();
        applyStimulus();
        wr_en = 2'b10;
        wr_addr[AW +: AW] = 5'd7;
        wr_data[DW +: DW] = 32'hAB;
        #1 checkOutput("t4_busy_wr", 32'(rd_busy[0]), 32'h0);
        applyStimulus();
        clear_inputs();
        checkOutput("t4_cnt_c4", 32'(busy_cnt), 32'h0);

        // Same-cycle claim and write: data bypasses, claim survives; flush beats a claim.
        wr_en = 2'b01;
        wr_addr[0 +: AW] = 5'd9;
        wr_data[0 +: DW] = 32'h5;
        clm_en = 2'b01;
        clm_addr[0 +: AW] = 5'd9;
        rd_addr[0 +: AW] = 5'd9;
        #1 checkOutput("t5_bypass_r9", rd_data[31:0], 32'h5);
        applyStimulus();
        clear_inputs();
        rd_addr[0 +: AW] = 5'd9;
        #1 checkOutput("t5_busy_r9", 32'(rd_busy[0]), 32'h1);
        flush = 1'b1;
        clm_en = 2'b01;
        clm_addr[0 +: AW] = 5'd9;
        applyStimulus();
        clear_inputs();
        checkOutput("t5_cnt_flush", 32'(busy_cnt), 32'h0);
        rd_addr[0 +: AW] = 5'd9;
        applyStimulus();

        for (int n = 0; n < 400; n++) begin
            random_inputs();
            applyStimulus();
        end

        // Asynchronous reset mid-run with live write/claim traffic.
        random_inputs();
        wr_en = 2'b11;
        rst = 1'b1;
        model_clear();
        #1;
        checkOutput("t1_cnt_async", 32'(busy_cnt), 32'h0);
        for (int i = 0; i < NRD; i++) checkOutput("t1_rd_in_rst", rd_data[i*DW +: DW], 32'h0);
        applyStimulus();
        rst = 1'b0;
        clear_inputs();
        for (int i = 0; i < NRD; i++) rd_addr[i*AW +: AW] = 5'($urandom_range(1, 7));
        applyStimulus();

`ifdef REGFILE_PARITY_EN
        wr_en = 2'b01;
        wr_addr[0 +: AW] = 5'd4;
        wr_data[0 +: DW] = 32'h0F;
        applyStimulus();
        clear_inputs();
        dut.mem[4][3] = ~dut.mem[4][3];
        m_reg[4] = m_reg[4] ^ 32'h8;
        m_bad[4] = 1'b1;
        rd_addr[0 +: AW] = 5'd4;
        applyStimulus();
        clear_inputs();
        checkOutput("t6_par_set", 32'(par_err), 32'h1);
        repeat (3) applyStimulus();
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        checkOutput("t6_par_clr", 32'(par_err), 32'h0);
`endif

        for (int n = 0; n < 100; n++) begin
            random_inputs();
            applyStimulus();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
